// File: rtl/fp_check_pkg.sv
// rtl/fp_check_pkg.sv - shared widths, verdict codes and IEEE754 classification helpers
//   fp_exp_w / fp_man_w : precision (0 half, 1 single, 2 double) -> field widths
//   V_NONE..V_FAIL      : verdict encoding
//   is_nan/is_inf/is_zero : operate on a value zero-extended to 64 bits
package fp_check_pkg;

    localparam logic [1:0] V_NONE = 2'd0;
    localparam logic [1:0] V_PASS = 2'd1;
    localparam logic [1:0] V_WARN = 2'd2;
    localparam logic [1:0] V_FAIL = 2'd3;

    function automatic int fp_exp_w(input int prec);
        case (prec)
            0:       return 5;
            2:       return 11;
            default: return 8;
        endcase
    endfunction

    function automatic int fp_man_w(input int prec);
        case (prec)
            0:       return 10;
            2:       return 52;
            default: return 23;
        endcase
    endfunction

    // Field extraction by shift-and-mask so one helper serves every precision.
    function automatic logic [63:0] exp_field(input logic [63:0] d, input int expW, input int manW);
        return (d >> manW) & ((64'd1 << expW) - 64'd1);
    endfunction

    function automatic logic [63:0] man_field(input logic [63:0] d, input int manW);
        return d & ((64'd1 << manW) - 64'd1);
    endfunction

    function automatic logic is_nan(input logic [63:0] d, input int expW, input int manW);
        return (exp_field(d, expW, manW) == ((64'd1 << expW) - 64'd1)) && (man_field(d, manW) != 64'd0);
    endfunction

    function automatic logic is_inf(input logic [63:0] d, input int expW, input int manW);
        return (exp_field(d, expW, manW) == ((64'd1 << expW) - 64'd1)) && (man_field(d, manW) == 64'd0);
    endfunction

    function automatic logic is_zero(input logic [63:0] d, input int expW, input int manW);
        return (exp_field(d, expW, manW) == 64'd0) && (man_field(d, manW) == 64'd0);
    endfunction

endpackage

// File: rtl/fp_check_fifo.sv
// rtl/fp_check_fifo.sv - in-order FIFO of expected {ID, data} entries
//   i_Clk, i_ARstN (async, active low), i_Clear (sync, wins over push/pop)
//   i_Push/iv_PushData, i_Pop/ov_PopData (first-word fall-through)
//   o_Full (registered), o_Empty
module fp_check_fifo #(
    parameter int pWidth = 35,
    parameter int pDepth = 16,
    localparam int pAw   = $clog2(pDepth)
) (
    input  logic              i_Clk,
    input  logic              i_ARstN,
    input  logic              i_Clear,
    input  logic              i_Push,
    input  logic [pWidth-1:0] iv_PushData,
    input  logic              i_Pop,
    output logic [pWidth-1:0] ov_PopData,
    output logic              o_Full,
    output logic              o_Empty
);

    logic [pWidth-1:0] rMem [pDepth];
    logic [pAw:0]      rWrPtr, rRdPtr;
    logic [pAw:0]      nxtWr, nxtRd, nxtCount;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign nxtWr    = rWrPtr + {{pAw{1'b0}}, i_Push};
    assign nxtRd    = rRdPtr + {{pAw{1'b0}}, i_Pop};
    assign nxtCount = nxtWr - nxtRd;

    assign ov_PopData = rMem[rRdPtr[pAw-1:0]];
    assign o_Empty    = (rWrPtr == rRdPtr);

    always_ff @(posedge i_Clk or negedge i_ARstN) begin
        if (!i_ARstN) begin
            rWrPtr <= '0;
            rRdPtr <= '0;
            o_Full <= 1'b0;
        end else if (i_Clear) begin
            rWrPtr <= '0;
            rRdPtr <= '0;
            o_Full <= 1'b0;
        end else begin
            rWrPtr <= nxtWr;
            rRdPtr <= nxtRd;
            o_Full <= (nxtCount == (pAw + 1)'(pDepth));
        end
    end

    // Storage needs no reset; a full push+pop reads the old slot before overwrite.
    always_ff @(posedge i_Clk) begin
        if (i_Push && !i_Clear)
            rMem[rWrPtr[pAw-1:0]] <= iv_PushData;
    end

endmodule

// File: rtl/fp_result_checker.sv
// rtl/fp_result_checker.sv - pairs expected and DUT results, classifies, keeps statistics
//   Expected side : iv_ExpData, i3_ExpID, i_ExpDv, o_ExpReady
//   DUT side      : iv_GotData, i3_GotID (0 = idle), i_GotOf
//   Verdict       : o2_Verdict, o_VerdictDv (two cycles after the DUT output)
//   Statistics    : ov_PassCnt/ov_WarnCnt/ov_FailCnt, o_Fail, o_Underrun, o_Overrun
//   Capture       : ov_FirstGot, ov_FirstExp, o3_FirstID of the first FAIL
module fp_result_checker
    import fp_check_pkg::*;
#(
    parameter int pPrecision  = 1,
    parameter int pDepth      = 16,
    parameter int pUlpTol     = 1,
    parameter int pZeroStrict = 0,
    parameter int pCntW       = 32,
    localparam int pExpW      = fp_exp_w(pPrecision),
    localparam int pManW      = fp_man_w(pPrecision),
    localparam int W          = pExpW + pManW + 1
) (
    input  logic             i_Clk,
    input  logic             i_ARstN,
    input  logic             i_Clear,
    input  logic [W-1:0]     iv_ExpData,
    input  logic [2:0]       i3_ExpID,
    input  logic             i_ExpDv,
    output logic             o_ExpReady,
    input  logic [W-1:0]     iv_GotData,
    input  logic [2:0]       i3_GotID,
    input  logic             i_GotOf,
    output logic [1:0]       o2_Verdict,
    output logic             o_VerdictDv,
    output logic [pCntW-1:0] ov_PassCnt,
    output logic [pCntW-1:0] ov_WarnCnt,
    output logic [pCntW-1:0] ov_FailCnt,
    output logic             o_Fail,
    output logic             o_Underrun,
    output logic             o_Overrun,
    output logic [W-1:0]     ov_FirstGot,
    output logic [W-1:0]     ov_FirstExp,
    output logic [2:0]       o3_FirstID
);

    logic         fifoFull, fifoEmpty;
    logic [W+2:0] fifoRdData;
    logic         gotValid, push, pop;

    assign gotValid   = (i3_GotID != 3'd0);
    assign pop        = gotValid && !fifoEmpty;
    // A full FIFO still accepts a push when the same cycle pops.
    assign push       = i_ExpDv && (!fifoFull || pop);
    assign o_ExpReady = !fifoFull;

    fp_check_fifo #(.pWidth(W + 3), .pDepth(pDepth)) uFifo (
        .i_Clk      (i_Clk),
        .i_ARstN    (i_ARstN),
        .i_Clear    (i_Clear),
        .i_Push     (push),
        .iv_PushData({i3_ExpID, iv_ExpData}),
        .i_Pop      (pop),
        .ov_PopData (fifoRdData),
        .o_Full     (fifoFull),
        .o_Empty    (fifoEmpty)
    );

    // Stage 1 registers
    logic         rS1Valid, rS1GotOf;
    logic [W-1:0] rS1Exp, rS1Got;
    logic [2:0]   rS1ExpId, rS1GotId;
    // Stage 2 operands kept alongside the verdict for first-fail capture
    logic [W-1:0] rS2Exp, rS2Got;
    logic [2:0]   rS2Id;

    logic [63:0]  e64, g64;
    logic         eNan, eInf, eZero, gNan, gInf, gZero, sameSign;
    logic [W-1:0] magE, magG, magDiff;
    logic [1:0]   verdict;

    assign e64      = 64'(rS1Exp);
    assign g64      = 64'(rS1Got);
    assign eNan     = is_nan(e64, pExpW, pManW);
    assign eInf     = is_inf(e64, pExpW, pManW);
    assign eZero    = is_zero(e64, pExpW, pManW);
    assign gNan     = is_nan(g64, pExpW, pManW);
    assign gInf     = is_inf(g64, pExpW, pManW);
    assign gZero    = is_zero(g64, pExpW, pManW);
    assign sameSign = (rS1Exp[W-1] == rS1Got[W-1]);
    assign magE     = {1'b0, rS1Exp[W-2:0]};
    assign magG     = {1'b0, rS1Got[W-2:0]};
    assign magDiff  = (magE >= magG) ? (magE - magG) : (magG - magE);

    // Ordered rules: the first match decides.
    always_comb begin
        verdict = V_FAIL;
        if (rS1ExpId != rS1GotId)
            verdict = V_FAIL;
        else if (eNan)
            verdict = gNan ? V_PASS : V_FAIL;
        else if (eInf)
            verdict = ((rS1Got == rS1Exp) || ((gNan || gInf) && rS1GotOf)) ? V_PASS : V_FAIL;
        else if (rS1Got == rS1Exp)
            verdict = V_PASS;
        else if (eZero && gZero)
            verdict = (pZeroStrict != 0) ? V_FAIL : V_WARN;
        else if ((pUlpTol != 0) && sameSign && !gNan && !gInf && (magDiff <= W'(pUlpTol)))
            verdict = V_WARN;
    end

    always_ff @(posedge i_Clk or negedge i_ARstN) begin
        if (!i_ARstN || i_Clear) begin
            rS1Valid    <= 1'b0;
            rS1GotOf    <= 1'b0;
            rS1Exp      <= '0;
            rS1Got      <= '0;
            rS1ExpId    <= '0;
            rS1GotId    <= '0;
            rS2Exp      <= '0;
            rS2Got      <= '0;
            rS2Id       <= '0;
            o2_Verdict  <= V_NONE;
            o_VerdictDv <= 1'b0;
            ov_PassCnt  <= '0;
            ov_WarnCnt  <= '0;
            ov_FailCnt  <= '0;
            o_Fail      <= 1'b0;
            o_Underrun  <= 1'b0;
            o_Overrun   <= 1'b0;
            ov_FirstGot <= '0;
            ov_FirstExp <= '0;
            o3_FirstID  <= '0;
        end else begin
            rS1Valid <= pop;
            if (pop) begin
                rS1Exp   <= fifoRdData[W-1:0];
                rS1ExpId <= fifoRdData[W+2:W];
                rS1Got   <= iv_GotData;
                rS1GotId <= i3_GotID;
                rS1GotOf <= i_GotOf;
            end

            o_VerdictDv <= rS1Valid;
            o2_Verdict  <= rS1Valid ? verdict : V_NONE;
            rS2Exp      <= rS1Exp;
            rS2Got      <= rS1Got;
            rS2Id       <= rS1ExpId;

            if (o_VerdictDv) begin
                case (o2_Verdict)
                    V_PASS:  if (ov_PassCnt != '1) ov_PassCnt <= ov_PassCnt + pCntW'(1);
                    V_WARN:  if (ov_WarnCnt != '1) ov_WarnCnt <= ov_WarnCnt + pCntW'(1);
                    V_FAIL:  if (ov_FailCnt != '1) ov_FailCnt <= ov_FailCnt + pCntW'(1);
                    default: ;
                endcase
                // o_Fail doubles as the capture freeze flag.
                if (o2_Verdict == V_FAIL && !o_Fail) begin
                    o_Fail      <= 1'b1;
                    ov_FirstGot <= rS2Got;
                    ov_FirstExp <= rS2Exp;
                    o3_FirstID  <= rS2Id;
                end
            end

            if (gotValid && fifoEmpty)
                o_Underrun <= 1'b1;
            if (i_ExpDv && fifoFull && !pop)
                o_Overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_result_checker.sv
// tb/tb_fp_result_checker.sv - directed bench over two configurations sharing one stimulus
module tb_fp_result_checker;

    localparam int W = 32;
    localparam logic [1:0] PASS = 2'd1;
    localparam logic [1:0] WARN = 2'd2;
    localparam logic [1:0] BAD  = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstN, clr, expDv, gotOf;
    logic [W-1:0] expData, gotData;
    logic [2:0]   expId, gotId;

    // Instance A: tolerance 1, lenient zero, depth 16, 32-bit counters
    logic         readyA, dvA, failFlagA, underA, overA;
    logic [1:0]   verdA;
    logic [31:0]  passA, warnA, failA;
    logic [W-1:0] firstGotA, firstExpA;
    logic [2:0]   firstIdA;
    // Instance B: no tolerance, strict zero, depth 4, 4-bit counters
    logic         readyB, dvB, failFlagB, underB, overB;
    logic [1:0]   verdB;
    logic [3:0]   passB, warnB, failB;
    logic [W-1:0] firstGotB, firstExpB;
    logic [2:0]   firstIdB;

    fp_result_checker #(.pPrecision(1), .pDepth(16), .pUlpTol(1), .pZeroStrict(0), .pCntW(32)) dutA (
        .i_Clk(clk), .i_ARstN(rstN), .i_Clear(clr),
        .iv_ExpData(expData), .i3_ExpID(expId), .i_ExpDv(expDv), .o_ExpReady(readyA),
        .iv_GotData(gotData), .i3_GotID(gotId), .i_GotOf(gotOf),
        .o2_Verdict(verdA), .o_VerdictDv(dvA),
        .ov_PassCnt(passA), .ov_WarnCnt(warnA), .ov_FailCnt(failA),
        .o_Fail(failFlagA), .o_Underrun(underA), .o_Overrun(overA),
        .ov_FirstGot(firstGotA), .ov_FirstExp(firstExpA), .o3_FirstID(firstIdA)
    );

    fp_result_checker #(.pPrecision(1), .pDepth(4), .pUlpTol(0), .pZeroStrict(1), .pCntW(4)) dutB (
        .i_Clk(clk), .i_ARstN(rstN), .i_Clear(clr),
        .iv_ExpData(expData), .i3_ExpID(expId), .i_ExpDv(expDv), .o_ExpReady(readyB),
        .iv_GotData(gotData), .i3_GotID(gotId), .i_GotOf(gotOf),
        .o2_Verdict(verdB), .o_VerdictDv(dvB),
        .ov_PassCnt(passB), .ov_WarnCnt(warnB), .ov_FailCnt(failB),
        .o_Fail(failFlagB), .o_Underrun(underB), .o_Overrun(overB),
        .ov_FirstGot(firstGotB), .ov_FirstExp(firstExpB), .o3_FirstID(firstIdB)
    );

    int nAsserts = 0;
    int nFails   = 0;
    int mPassA = 0, mWarnA = 0, mFailA = 0;
    int mPassB = 0, mWarnB = 0, mFailB = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        mPassA = 0; mWarnA = 0; mFailA = 0;
        mPassB = 0; mWarnB = 0; mFailB = 0;
    endtask

    task automatic countVerdicts(input logic [1:0] vA, input logic [1:0] vB);
        case (vA)
            PASS:    mPassA++;
            WARN:    mWarnA++;
            default: mFailA++;
        endcase
        case (vB)
            PASS:    if (mPassB < 15) mPassB++;
            WARN:    if (mWarnB < 15) mWarnB++;
            default: if (mFailB < 15) mFailB++;
        endcase
    endtask

    task automatic chkCounts(input string tag);
        chk({tag, "/passA"}, 64'(passA), 64'(mPassA));
        chk({tag, "/warnA"}, 64'(warnA), 64'(mWarnA));
        chk({tag, "/failA"}, 64'(failA), 64'(mFailA));
        chk({tag, "/passB"}, 64'(passB), 64'(mPassB));
        chk({tag, "/warnB"}, 64'(warnB), 64'(mWarnB));
        chk({tag, "/failB"}, 64'(failB), 64'(mFailB));
    endtask

    // Push in cycle P, DUT output in N = P+1, verdict at N+2, counters at N+3.
    task automatic compare(input string tag, input logic [W-1:0] e, input logic [2:0] eid,
                           input logic [W-1:0] g, input logic [2:0] gid, input logic of,
                           input logic [1:0] vA, input logic [1:0] vB);
        expData = e; expId = eid; expDv = 1'b1;
        step();
        expDv = 1'b0;
        gotData = g; gotId = gid; gotOf = of;
        step();
        gotId = 3'd0; gotOf = 1'b0;
        chk({tag, "/dvEarly"}, 64'(dvA), 64'd0);
        step();
        chk({tag, "/dvA"}, 64'(dvA), 64'd1);
        chk({tag, "/verdA"}, 64'(verdA), 64'(vA));
        chk({tag, "/dvB"}, 64'(dvB), 64'd1);
        chk({tag, "/verdB"}, 64'(verdB), 64'(vB));
        step();
        countVerdicts(vA, vB);
        chkCounts(tag);
    endtask

    task automatic pulseClear();
        clr = 1'b1;
        step();
        clr = 1'b0;
        clearModel();
    endtask

    initial begin
        rstN = 1'b0; clr = 1'b0; expDv = 1'b0; gotOf = 1'b0;
        expData = '0; gotData = '0; expId = 3'd0; gotId = 3'd0;
        step(); step();

        // Reset state
        chk("rst/readyA", 64'(readyA), 64'd1);
        chk("rst/readyB", 64'(readyB), 64'd1);
        chk("rst/dvA", 64'(dvA), 64'd0);
        chk("rst/verdA", 64'(verdA), 64'd0);
        chk("rst/failFlagA", 64'(failFlagA), 64'd0);
        chk("rst/underA", 64'(underA), 64'd0);
        chk("rst/overB", 64'(overB), 64'd0);
        chkCounts("rst");
        rstN = 1'b1;
        step();

        // Classification vectors
        compare("exact", 32'h3F800000, 3'd1, 32'h3F800000, 3'd1, 1'b0, PASS, PASS);
        compare("ulp1", 32'h40490FDB, 3'd2, 32'h40490FDC, 3'd2, 1'b0, WARN, BAD);
        compare("infOf", 32'h7F800000, 3'd3, 32'h7F800000, 3'd3, 1'b1, PASS, PASS);
        compare("infBad", 32'h7F800000, 3'd4, 32'h7F800001, 3'd4, 1'b0, BAD, BAD);
        compare("nan", 32'h7FC00000, 3'd5, 32'h7FA00001, 3'd5, 1'b0, PASS, PASS);
        compare("zeroSign", 32'h00000000, 3'd6, 32'h80000000, 3'd6, 1'b0, WARN, BAD);
        compare("idMis", 32'h3F800000, 3'd7, 32'h3F800000, 3'd1, 1'b0, BAD, BAD);
        compare("ulp2", 32'h3F800000, 3'd1, 32'h3F800002, 3'd1, 1'b0, BAD, BAD);
        compare("signFlip", 32'h3F800000, 3'd2, 32'hBF800000, 3'd2, 1'b0, BAD, BAD);
        compare("infOfPay", 32'h7F800000, 3'd3, 32'h7F800005, 3'd3, 1'b1, PASS, PASS);

        // First-fail capture is frozen at the first FAIL of each instance
        chk("cap/failFlagA", 64'(failFlagA), 64'd1);
        chk("cap/gotA", 64'(firstGotA), 64'h7F800001);
        chk("cap/expA", 64'(firstExpA), 64'h7F800000);
        chk("cap/idA", 64'(firstIdA), 64'd4);
        chk("cap/failFlagB", 64'(failFlagB), 64'd1);
        chk("cap/gotB", 64'(firstGotB), 64'h40490FDC);
        chk("cap/expB", 64'(firstExpB), 64'h40490FDB);
        chk("cap/idB", 64'(firstIdB), 64'd2);

        // Synchronous clear
        pulseClear();
        chkCounts("clr");
        chk("clr/failFlagB", 64'(failFlagB), 64'd0);
        chk("clr/gotB", 64'(firstGotB), 64'd0);

        // Push and DUT output together while empty: underrun, entry stored, no verdict
        expData = 32'h3F800000; expId = 3'd1; expDv = 1'b1;
        gotData = 32'h3F800000; gotId = 3'd1;
        step();
        expDv = 1'b0; gotId = 3'd0;
        chk("und/underA", 64'(underA), 64'd1);
        chk("und/underB", 64'(underB), 64'd1);
        step();
        step();
        chk("und/dvA", 64'(dvA), 64'd0);
        chk("und/dvB", 64'(dvB), 64'd0);
        gotData = 32'h3F800000; gotId = 3'd1;
        step();
        gotId = 3'd0;
        step();
        chk("und/storedA", 64'(verdA), 64'(PASS));
        chk("und/storedB", 64'(verdB), 64'(PASS));
        countVerdicts(PASS, PASS);

        // Fill: B (depth 4) goes full after the 4th push and overruns on the 5th
        for (int i = 1; i <= 5; i++) begin
            expData = 32'h3F800000; expId = 3'(i); expDv = 1'b1;
            step();
            if (i == 4) begin
                chk("fill/readyB4", 64'(readyB), 64'd0);
                chk("fill/readyA4", 64'(readyA), 64'd1);
                chk("fill/overB4", 64'(overB), 64'd0);
            end
        end
        expDv = 1'b0;
        chk("fill/overB", 64'(overB), 64'd1);
        chk("fill/overA", 64'(overA), 64'd0);

        // Full with simultaneous push and pop: occupancy unchanged
        expData = 32'h3F800000; expId = 3'd6; expDv = 1'b1;
        gotData = 32'h3F800000; gotId = 3'd1;
        step();
        expDv = 1'b0; gotId = 3'd0;
        chk("full/readyB", 64'(readyB), 64'd0);
        step();
        chk("full/verdA", 64'(verdA), 64'(PASS));
        chk("full/verdB", 64'(verdB), 64'(PASS));

        // Saturation of the 4-bit counter
        pulseClear();
        for (int i = 0; i < 20; i++)
            compare("sat", 32'h3F800000, 3'd1, 32'h3F800000, 3'd2, 1'b0, BAD, BAD);
        chk("sat/failB15", 64'(failB), 64'd15);
        chk("sat/failA20", 64'(failA), 64'd20);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            expData = 32'h3F800000; expId = 3'd1; expDv = 1'b1;
            step();
        end
        expDv = 1'b0;
        gotData = 32'h3F800000; gotId = 3'd1;
        step();
        gotId = 3'd0;
        #2 rstN = 1'b0;
        #1;
        chk("arst/dvA", 64'(dvA), 64'd0);
        chk("arst/verdA", 64'(verdA), 64'd0);
        chk("arst/failA", 64'(failA), 64'd0);
        chk("arst/failB", 64'(failB), 64'd0);
        chk("arst/failFlagA", 64'(failFlagA), 64'd0);
        chk("arst/firstGotA", 64'(firstGotA), 64'd0);
        chk("arst/firstIdB", 64'(firstIdB), 64'd0);
        chk("arst/overB", 64'(overB), 64'd0);
        chk("arst/readyB", 64'(readyB), 64'd1);
        step();
        chk("arst/dvHeld", 64'(dvA), 64'd0);
        rstN = 1'b1;
        gotData = 32'h3F800000; gotId = 3'd1;
        step();
        gotId = 3'd0;
        chk("arst/underA", 64'(underA), 64'd1);
        chk("arst/underB", 64'(underB), 64'd1);
        step();
        step();
        chk("arst/noVerdA", 64'(dvA), 64'd0);
        chk("arst/noVerdB", 64'(dvB), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
